axi4_lite_slave: RTL and testbench

//   AXI4-Lite slave endpoint terminating the transactions issued by axi4_lite_master.

---
 rtl/axi4_lite_pkg.sv | 31 +++
 rtl/axi4_lite_regfile.sv | 57 +++++
 rtl/axi4_lite_slave.sv | 221 ++++++++++++++++++++++
 tb/tb_axi4_lite_slave.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_pkg
//  Description : Shared AXI4-Lite definitions: response codes, handshake FSM
//                state encodings and a response-selection helper.
//  Revision    : 1.0  initial release
// ============================================================================
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // In-range accesses complete normally, anything else is a slave error
  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_regfile
//  Description : NUM_REGS x DATA_WIDTH register bank with one byte-strobed
//                write port, one combinational read port and a flat export.
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_lite_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IDX_WIDTH  = $clog2(NUM_REGS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_we,
  input  logic [IDX_WIDTH-1:0]         i_widx,
  input  logic [DATA_WIDTH-1:0]        i_wdata,
  input  logic [DATA_WIDTH/8-1:0]      i_wstrb,
  input  logic [IDX_WIDTH-1:0]         i_ridx,
  output logic [DATA_WIDTH-1:0]        o_rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs_flat
);

  localparam int                 c_STRBW = DATA_WIDTH / 8;
  localparam logic [IDX_WIDTH:0] c_NREGS = (IDX_WIDTH + 1)'(NUM_REGS);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [IDX_WIDTH-1:0] c_IDX = IDX_WIDTH'(gi);
    logic [DATA_WIDTH-1:0] r_q;

    // Byte-lane update of this register when it is the write target
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_q <= '0;
      end else if (i_we && (i_widx == c_IDX)) begin
        for (int k = 0; k < c_STRBW; k++) begin
          if (i_wstrb[k]) begin
            r_q[k*8 +: 8] <= i_wdata[k*8 +: 8];
          end
        end
      end
    end

    assign o_regs_flat[gi*DATA_WIDTH +: DATA_WIDTH] = r_q;
  end

  // Read port taps the flat bus; indices past the bank (non power-of-two
  // NUM_REGS) return zero instead of an undefined slice
  always_comb begin
    o_rdata = '0;
    if ({1'b0, i_ridx} < c_NREGS) begin
      o_rdata = o_regs_flat[i_ridx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_slave
//  Description : AXI4-Lite slave endpoint. Independent write and read
//                handshake FSMs in front of a byte-strobed register bank,
//                with OKAY/SLVERR decode and a flat register export.
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_lite_slave
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGS      = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [ADDRESS_WIDTH-1:0]       S_AXI_AWADDR,
  input  logic                           S_AXI_AWVALID,
  output logic                           S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                           S_AXI_WVALID,
  output logic                           S_AXI_WREADY,
  output logic [1:0]                     S_AXI_BRESP,
  output logic                           S_AXI_BVALID,
  input  logic                           S_AXI_BREADY,
  input  logic [ADDRESS_WIDTH-1:0]       S_AXI_ARADDR,
  input  logic                           S_AXI_ARVALID,
  output logic                           S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                     S_AXI_RRESP,
  output logic                           S_AXI_RVALID,
  input  logic                           S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  localparam int c_STRBW = DATA_WIDTH / 8;
  localparam int c_LSB   = $clog2(c_STRBW);
  localparam int c_IDXW  = $clog2(NUM_REGS);
  // Byte size of the register window; addresses at or above it are errors
  localparam logic [ADDRESS_WIDTH-1:0] c_SPAN = ADDRESS_WIDTH'(NUM_REGS * c_STRBW);

  // --------------------------------------------------------------------------
  // Write path state
  // --------------------------------------------------------------------------
  wr_state_e                r_wstate;
  logic                     r_awready;
  logic                     r_wready;
  logic                     r_aw_got;
  logic                     r_w_got;
  logic                     r_bvalid;
  logic [1:0]               r_bresp;
  logic [ADDRESS_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [c_STRBW-1:0]       r_wstrb;

  logic                     w_aw_hs;
  logic                     w_w_hs;
  logic [ADDRESS_WIDTH-1:0] w_awaddr;
  logic [DATA_WIDTH-1:0]    w_wdata;
  logic [c_STRBW-1:0]       w_wstrb;
  logic                     w_commit;
  logic                     w_wr_in_range;
  logic                     w_we;
  logic [c_IDXW-1:0]        w_widx;

  // --------------------------------------------------------------------------
  // Read path state
  // --------------------------------------------------------------------------
  rd_state_e                r_rstate;
  logic                     r_arready;
  logic                     r_rvalid;
  logic [1:0]               r_rresp;
  logic [DATA_WIDTH-1:0]    r_rdata;

  logic                     w_ar_hs;
  logic                     w_rd_in_range;
  logic [c_IDXW-1:0]        w_ridx;
  logic [DATA_WIDTH-1:0]    w_rd_word;

  // Ready is only ever high while the channel is still empty, so a handshake
  // is simply VALID qualified by our registered READY
  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs  = S_AXI_WVALID  & r_wready;

  // A channel arriving this cycle is used directly so the commit can happen
  // on the same edge as the second handshake
  assign w_awaddr = r_aw_got ? r_awaddr : S_AXI_AWADDR;
  assign w_wdata  = r_w_got  ? r_wdata  : S_AXI_WDATA;
  assign w_wstrb  = r_w_got  ? r_wstrb  : S_AXI_WSTRB;

  assign w_commit      = (r_wstate == W_IDLE) & (r_aw_got | w_aw_hs) & (r_w_got | w_w_hs);
  assign w_wr_in_range = (w_awaddr < c_SPAN);
  assign w_we          = w_commit & w_wr_in_range;
  assign w_widx        = w_awaddr[c_LSB +: c_IDXW];

  assign w_ar_hs       = S_AXI_ARVALID & r_arready;
  assign w_rd_in_range = (S_AXI_ARADDR < c_SPAN);
  assign w_ridx        = S_AXI_ARADDR[c_LSB +: c_IDXW];

  axi4_lite_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_WIDTH  (c_IDXW)
  ) u_regfile (
    .i_clk       (ACLK),
    .i_rst       (ARESET),
    .i_we        (w_we),
    .i_widx      (w_widx),
    .i_wdata     (w_wdata),
    .i_wstrb     (w_wstrb),
    .i_ridx      (w_ridx),
    .o_rdata     (w_rd_word),
    .o_regs_flat (regs_flat)
  );

  // Write FSM: collect AW and W in any order, commit, then hold B until taken
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_got  <= 1'b0;
            r_w_got   <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= resp_for(w_wr_in_range);
          end else begin
            if (w_aw_hs) begin
              r_aw_got  <= 1'b1;
              r_awaddr  <= S_AXI_AWADDR;
              r_awready <= 1'b0;
            end else if (!r_aw_got) begin
              r_awready <= 1'b1;
            end
            if (w_w_hs) begin
              r_w_got  <= 1'b1;
              r_wdata  <= S_AXI_WDATA;
              r_wstrb  <= S_AXI_WSTRB;
              r_wready <= 1'b0;
            end else if (!r_w_got) begin
              r_wready <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: begin
          r_wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: sample the register on the AR handshake, hold R until taken
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rresp   <= resp_for(w_rd_in_range);
            r_rdata   <= w_rd_in_range ? w_rd_word : '0;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: begin
          r_rstate <= R_IDLE;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_lite_slave
//  Description : Directed scoreboard bench for axi4_lite_slave. Stimulus
//                pushes expected B/R responses; a monitor pops them on each
//                handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi4_lite_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 8;

  logic              clk = 1'b0;
  logic              arst;
  logic [AW-1:0]     awaddr;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AW-1:0]     araddr;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NR*DW-1:0]  regs_flat;

  typedef struct {
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } rexp_t;

  logic [1:0]   exp_b[$];
  rexp_t        exp_r[$];
  logic [NR*DW-1:0] exp_flat;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi4_lite_slave #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .NUM_REGS      (NR)
  ) dut (
    .ACLK          (clk),
    .ARESET        (arst),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .regs_flat     (regs_flat)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every B or R handshake consumes the oldest expected response
  always @(negedge clk) begin
    if (!arst) begin
      if (bvalid && bready) begin
        chk("b_expected", 256'(exp_b.size() > 0), 256'(1));
        if (exp_b.size() > 0) begin
          chk("bresp", 256'(bresp), 256'(exp_b.pop_front()));
        end
      end
      if (rvalid && rready) begin
        chk("r_expected", 256'(exp_r.size() > 0), 256'(1));
        if (exp_r.size() > 0) begin
          rexp_t e;
          e = exp_r.pop_front();
          chk("rresp", 256'(rresp), 256'(e.resp));
          chk("rdata", 256'(rdata), 256'(e.data));
        end
      end
    end
  end

  task automatic wait_b_clear(input string name);
    for (int i = 0; i < 20; i++) begin
      if (!bvalid) break;
      tick();
    end
    chk(name, 256'(bvalid), 256'(0));
  endtask

  task automatic wait_r_clear(input string name);
    for (int i = 0; i < 20; i++) begin
      if (!rvalid) break;
      tick();
    end
    chk(name, 256'(rvalid), 256'(0));
  endtask

  // AW and W presented together; BVALID due one cycle after the handshake
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [3:0] s, input logic [1:0] resp, input string name);
    awaddr = a; awvalid = 1'b1;
    wdata = d;  wstrb = s; wvalid = 1'b1;
    exp_b.push_back(resp);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk({name, "_bvalid_next"}, 256'(bvalid), 256'(1));
    chk({name, "_awready_low"}, 256'(awready), 256'(0));
    chk({name, "_wready_low"},  256'(wready),  256'(0));
    wait_b_clear({name, "_b_done"});
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] resp, input string name);
    rexp_t e;
    e.resp = resp; e.data = d;
    araddr = a; arvalid = 1'b1;
    exp_r.push_back(e);
    tick();
    arvalid = 1'b0;
    chk({name, "_rvalid_next"}, 256'(rvalid), 256'(1));
    chk({name, "_arready_low"}, 256'(arready), 256'(0));
    wait_r_clear({name, "_r_done"});
    tick();
    chk({name, "_arready_back"}, 256'(arready), 256'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    exp_flat = '0;

    // 1. Reset state and ready rise after release
    repeat (3) tick();
    chk("rst_awready", 256'(awready), 256'(0));
    chk("rst_wready",  256'(wready),  256'(0));
    chk("rst_arready", 256'(arready), 256'(0));
    chk("rst_bvalid",  256'(bvalid),  256'(0));
    chk("rst_bresp",   256'(bresp),   256'(0));
    chk("rst_rvalid",  256'(rvalid),  256'(0));
    chk("rst_rdata",   256'(rdata),   256'(0));
    chk("rst_rresp",   256'(rresp),   256'(0));
    chk("rst_regs",    256'(regs_flat), 256'(0));
    arst = 1'b0;
    #1;
    chk("rel_awready_before_edge", 256'(awready), 256'(0));
    tick();
    chk("rel_awready", 256'(awready), 256'(1));
    chk("rel_wready",  256'(wready),  256'(1));
    chk("rel_arready", 256'(arready), 256'(1));

    // 2. Same-cycle AW+W then read back
    bready = 1'b1; rready = 1'b1;
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 2'b00, "t2");
    exp_flat[63:32] = 32'hDEADBEEF;
    chk("t2_regs", 256'(regs_flat), 256'(exp_flat));
    chk("t2_awready_back", 256'(awready), 256'(1));
    do_read(32'h4, 32'hDEADBEEF, 2'b00, "t2r");

    // 3. W three cycles ahead of AW, partial strobes
    wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1'b1;
    exp_b.push_back(2'b00);
    tick();
    wvalid = 1'b0;
    chk("t3_wready_low", 256'(wready), 256'(0));
    chk("t3_awready_hi", 256'(awready), 256'(1));
    chk("t3_no_b_1", 256'(bvalid), 256'(0));
    tick();
    chk("t3_no_b_2", 256'(bvalid), 256'(0));
    tick();
    chk("t3_no_b_3", 256'(bvalid), 256'(0));
    chk("t3_reg2_unwritten", 256'(regs_flat[95:64]), 256'(0));
    awaddr = 32'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t3_bvalid", 256'(bvalid), 256'(1));
    exp_flat[95:64] = 32'h00220044;
    chk("t3_regs", 256'(regs_flat), 256'(exp_flat));
    wait_b_clear("t3_b_done");
    do_read(32'h8, 32'h00220044, 2'b00, "t3r");

    // 4. Out-of-range and boundary addresses
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 2'b10, "t4_oor");
    chk("t4_regs_unchanged", 256'(regs_flat), 256'(exp_flat));
    do_read(32'h40, 32'h0, 2'b10, "t4r_oor");
    do_write(32'h1C, 32'hCAFEF00D, 4'hF, 2'b00, "t4_last");
    exp_flat[255:224] = 32'hCAFEF00D;
    chk("t4_regs_last", 256'(regs_flat), 256'(exp_flat));
    do_read(32'h1F, 32'hCAFEF00D, 2'b00, "t4r_lowbits");
    do_write(32'h20, 32'h12345678, 4'hF, 2'b10, "t4_edge");
    chk("t4_regs_edge", 256'(regs_flat), 256'(exp_flat));
    do_read(32'h20, 32'h0, 2'b10, "t4r_edge");

    // 5. Concurrent write+read on reg7 with both responses back-pressured
    bready = 1'b0; rready = 1'b0;
    awaddr = 32'h1C; wdata = 32'h12345678; wstrb = 4'h3;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h1C; arvalid = 1'b1;
    exp_b.push_back(2'b00);
    exp_r.push_back('{resp: 2'b00, data: 32'hCAFEF00D});
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_flat[255:224] = 32'hCAFE5678;
    chk("t5_regs_new", 256'(regs_flat), 256'(exp_flat));
    for (int i = 0; i < 5; i++) begin
      chk("t5_bvalid",  256'(bvalid),  256'(1));
      chk("t5_bresp",   256'(bresp),   256'(0));
      chk("t5_rvalid",  256'(rvalid),  256'(1));
      chk("t5_rdata",   256'(rdata),   256'(32'hCAFEF00D));
      chk("t5_rresp",   256'(rresp),   256'(0));
      chk("t5_awready", 256'(awready), 256'(0));
      chk("t5_wready",  256'(wready),  256'(0));
      chk("t5_arready", 256'(arready), 256'(0));
      tick();
    end
    bready = 1'b1; rready = 1'b1;
    tick();
    chk("t5_bvalid_done", 256'(bvalid), 256'(0));
    chk("t5_rvalid_done", 256'(rvalid), 256'(0));
    chk("t5_awready_back", 256'(awready), 256'(1));
    chk("t5_wready_back",  256'(wready),  256'(1));
    chk("t5_arready_back", 256'(arready), 256'(1));

    // 6. Reset pulsed while a write response is pending
    bready = 1'b0;
    awaddr = 32'hC; wdata = 32'h00000055; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    exp_b.push_back(2'b00);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t6_bvalid_pending", 256'(bvalid), 256'(1));
    arst = 1'b1;
    #1;
    chk("t6_bvalid_cleared", 256'(bvalid), 256'(0));
    chk("t6_regs_cleared",   256'(regs_flat), 256'(0));
    chk("t6_awready_rst",    256'(awready), 256'(0));
    exp_b.delete();
    exp_flat = '0;
    tick();
    tick();
    arst = 1'b0;
    bready = 1'b1;
    tick();
    chk("t6_awready_back", 256'(awready), 256'(1));
    for (int i = 0; i < 5; i++) begin
      chk("t6_no_b", 256'(bvalid), 256'(0));
      tick();
    end
    do_read(32'hC, 32'h0, 2'b00, "t6r");

    chk("end_b_queue_empty", 256'(exp_b.size()), 256'(0));
    chk("end_r_queue_empty", 256'(exp_r.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
